// File: rtl/cam_table_pkg.sv
// Shared types and default sizing for the MAC address CAM table.
`default_nettype none

package cam_table_pkg;

   localparam int C_KEY_WIDTH   = 48;
   localparam int C_VALUE_WIDTH = 4;
   localparam int C_TABLE_DEPTH = 32;
   localparam int C_AGE_WIDTH   = 4;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } fsm_state_t;

   typedef struct packed {
      logic                     valid;
      logic [C_KEY_WIDTH-1:0]   key;
      logic [C_VALUE_WIDTH-1:0] value;
      logic [C_AGE_WIDTH-1:0]   age;
   } cam_entry_t;

endpackage

`default_nettype wire

// File: rtl/cam_priority_encoder.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
`default_nettype none

module cam_priority_encoder #(
   parameter int WIDTH = 32,
   parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o = IDX_W'(i);
            any_o = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_cam_table.sv
// MAC learning table: associative key->value store with aging, refresh and sequential flush.
`default_nettype none

module mac_cam_table
   import cam_table_pkg::*;
#(
   parameter int KEY_WIDTH   = C_KEY_WIDTH,
   parameter int VALUE_WIDTH = C_VALUE_WIDTH,
   parameter int TABLE_DEPTH = C_TABLE_DEPTH,
   parameter int AGE_WIDTH   = C_AGE_WIDTH,
   parameter int IDX_W       = $clog2(TABLE_DEPTH)
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   learn_valid_i,
   output logic                   learn_ready_o,
   input  logic [KEY_WIDTH-1:0]   learn_key_i,
   input  logic [VALUE_WIDTH-1:0] learn_value_i,
   output logic                   learn_dropped_o,
   input  logic                   lookup_valid_i,
   input  logic [KEY_WIDTH-1:0]   lookup_key_i,
   output logic                   result_valid_o,
   output logic                   result_hit_o,
   output logic [VALUE_WIDTH-1:0] result_value_o,
   output logic [IDX_W-1:0]       result_index_o,
   input  logic                   age_tick_i,
   input  logic                   flush_i,
   output logic                   flush_done_o,
   output logic [IDX_W:0]         entry_count_o
);

   localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;
   localparam logic [AGE_WIDTH-1:0] AGE_ONE  = AGE_WIDTH'(1);
   localparam logic [IDX_W-1:0]     PTR_LAST = IDX_W'(TABLE_DEPTH - 1);

   logic [TABLE_DEPTH-1:0] valid_q, valid_d;
   logic [KEY_WIDTH-1:0]   key_q   [TABLE_DEPTH];
   logic [KEY_WIDTH-1:0]   key_d   [TABLE_DEPTH];
   logic [VALUE_WIDTH-1:0] value_q [TABLE_DEPTH];
   logic [VALUE_WIDTH-1:0] value_d [TABLE_DEPTH];
   logic [AGE_WIDTH-1:0]   age_q   [TABLE_DEPTH];
   logic [AGE_WIDTH-1:0]   age_d   [TABLE_DEPTH];

   fsm_state_t       state_q, state_d;
   logic [IDX_W-1:0] flush_ptr_q, flush_ptr_d;
   logic             flush_done_q, flush_done_d;

   logic                   learn_dropped_q;
   logic                   result_valid_q;
   logic                   result_hit_q;
   logic [VALUE_WIDTH-1:0] result_value_q;
   logic [IDX_W-1:0]       result_index_q;
   logic [IDX_W:0]         entry_count_q, entry_count_d;

   logic [TABLE_DEPTH-1:0] learn_match_w;
   logic [TABLE_DEPTH-1:0] lookup_match_w;
   logic [TABLE_DEPTH-1:0] free_w;
   logic [IDX_W-1:0]       learn_idx_w, free_idx_w, lookup_idx_w;
   logic                   learn_hit_w, free_any_w, lookup_hit_w;
   logic                   learn_fire_w, learn_write_w, tick_en_w, flushing_w;
   logic [IDX_W-1:0]       learn_slot_w;

   generate
      for (genvar gi = 0; gi < TABLE_DEPTH; gi++) begin : g_match
         assign learn_match_w[gi]  = valid_q[gi] && (key_q[gi] == learn_key_i);
         assign lookup_match_w[gi] = valid_q[gi] && (key_q[gi] == lookup_key_i);
         assign free_w[gi]         = ~valid_q[gi];
      end
   endgenerate

   cam_priority_encoder #(.WIDTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_learn_enc (
      .vec_i (learn_match_w),
      .idx_o (learn_idx_w),
      .any_o (learn_hit_w)
   );

   cam_priority_encoder #(.WIDTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_free_enc (
      .vec_i (free_w),
      .idx_o (free_idx_w),
      .any_o (free_any_w)
   );

   cam_priority_encoder #(.WIDTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_lookup_enc (
      .vec_i (lookup_match_w),
      .idx_o (lookup_idx_w),
      .any_o (lookup_hit_w)
   );

   assign flushing_w    = (state_q == FLUSH);
   assign learn_ready_o = ~flushing_w;
   assign learn_fire_w  = learn_valid_i & ~flushing_w;
   assign tick_en_w     = age_tick_i & ~flushing_w;
   assign learn_write_w = learn_fire_w & (learn_hit_w | free_any_w);
   assign learn_slot_w  = learn_hit_w ? learn_idx_w : free_idx_w;

   always_comb begin
      state_d      = state_q;
      flush_ptr_d  = flush_ptr_q;
      flush_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_i) begin
               state_d     = FLUSH;
               flush_ptr_d = '0;
            end
         end
         FLUSH: begin
            if (flush_ptr_q == PTR_LAST) begin
               state_d      = IDLE;
               flush_ptr_d  = '0;
               flush_done_d = 1'b1;
            end else begin
               flush_ptr_d = flush_ptr_q + IDX_W'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            flush_ptr_d = '0;
         end
      endcase
   end

   // Priority per slot: flush clear, then learn write, then aging.
   always_comb begin
      valid_d = valid_q;
      key_d   = key_q;
      value_d = value_q;
      age_d   = age_q;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         if (flushing_w && (flush_ptr_q == IDX_W'(i))) begin
            valid_d[i] = 1'b0;
            key_d[i]   = '0;
            value_d[i] = '0;
            age_d[i]   = '0;
         end else if (learn_write_w && (learn_slot_w == IDX_W'(i))) begin
            valid_d[i] = 1'b1;
            key_d[i]   = learn_key_i;
            value_d[i] = learn_value_i;
            age_d[i]   = AGE_MAX;
         end else if (tick_en_w && valid_q[i] && (age_q[i] != '0)) begin
            age_d[i] = age_q[i] - AGE_ONE;
            if (age_q[i] == AGE_ONE) begin
               valid_d[i] = 1'b0;
            end
         end
      end
   end

   always_comb begin
      entry_count_d = '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
         entry_count_d = entry_count_d + (IDX_W+1)'(valid_q[i]);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q         <= IDLE;
         flush_ptr_q     <= '0;
         flush_done_q    <= 1'b0;
         valid_q         <= '0;
         learn_dropped_q <= 1'b0;
         result_valid_q  <= 1'b0;
         result_hit_q    <= 1'b0;
         result_value_q  <= '0;
         result_index_q  <= '0;
         entry_count_q   <= '0;
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            key_q[i]   <= '0;
            value_q[i] <= '0;
            age_q[i]   <= '0;
         end
      end else begin
         state_q         <= state_d;
         flush_ptr_q     <= flush_ptr_d;
         flush_done_q    <= flush_done_d;
         valid_q         <= valid_d;
         key_q           <= key_d;
         value_q         <= value_d;
         age_q           <= age_d;
         learn_dropped_q <= learn_fire_w & ~learn_hit_w & ~free_any_w;
         result_valid_q  <= lookup_valid_i;
         result_hit_q    <= lookup_valid_i & lookup_hit_w;
         result_value_q  <= (lookup_valid_i && lookup_hit_w) ? value_q[lookup_idx_w] : '0;
         result_index_q  <= (lookup_valid_i && lookup_hit_w) ? lookup_idx_w : '0;
         entry_count_q   <= entry_count_d;
      end
   end

   assign learn_dropped_o = learn_dropped_q;
   assign result_valid_o  = result_valid_q;
   assign result_hit_o    = result_hit_q;
   assign result_value_o  = result_value_q;
   assign result_index_o  = result_index_q;
   assign flush_done_o    = flush_done_q;
   assign entry_count_o   = entry_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_cam_table.sv
// Directed self-checking bench for mac_cam_table (default parameters).
`default_nettype none

module tb_mac_cam_table;

   logic        clock_i = 1'b0;
   logic        reset_i;
   logic        learn_valid_i;
   logic        learn_ready_o;
   logic [47:0] learn_key_i;
   logic [3:0]  learn_value_i;
   logic        learn_dropped_o;
   logic        lookup_valid_i;
   logic [47:0] lookup_key_i;
   logic        result_valid_o;
   logic        result_hit_o;
   logic [3:0]  result_value_o;
   logic [4:0]  result_index_o;
   logic        age_tick_i;
   logic        flush_i;
   logic        flush_done_o;
   logic [5:0]  entry_count_o;

   int total = 0;
   int bad   = 0;

   always #5 clock_i = ~clock_i;

   mac_cam_table dut (
      .clock_i         (clock_i),
      .reset_i         (reset_i),
      .learn_valid_i   (learn_valid_i),
      .learn_ready_o   (learn_ready_o),
      .learn_key_i     (learn_key_i),
      .learn_value_i   (learn_value_i),
      .learn_dropped_o (learn_dropped_o),
      .lookup_valid_i  (lookup_valid_i),
      .lookup_key_i    (lookup_key_i),
      .result_valid_o  (result_valid_o),
      .result_hit_o    (result_hit_o),
      .result_value_o  (result_value_o),
      .result_index_o  (result_index_o),
      .age_tick_i      (age_tick_i),
      .flush_i         (flush_i),
      .flush_done_o    (flush_done_o),
      .entry_count_o   (entry_count_o)
   );

   typedef struct {
      logic        lv;
      logic [47:0] lk;
      logic [3:0]  lval;
      logic        qv;
      logic [47:0] qk;
      logic        e_drop;
      logic        e_rv;
      logic        e_hit;
      logic [3:0]  e_val;
      logic [4:0]  e_idx;
      logic [5:0]  e_cnt;
   } vec_t;

   localparam logic [47:0] K0 = 48'h0000_1111_2222;
   localparam logic [47:0] K1 = 48'h0000_AAAA_0001;
   localparam logic [47:0] K2 = 48'h0000_BBBB_0002;
   localparam logic [47:0] KA = 48'h00C0_FFEE_0001;
   localparam logic [47:0] KB = 48'h00C0_FFEE_0002;

   function automatic logic [47:0] fkey(input int i);
      return 48'h0A00_0000_0000 | 48'(i);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic lv, input logic [47:0] lk, input logic [3:0] lval,
                        input logic qv, input logic [47:0] qk, input logic tk, input logic fl);
      learn_valid_i  = lv;
      learn_key_i    = lk;
      learn_value_i  = lval;
      lookup_valid_i = qv;
      lookup_key_i   = qk;
      age_tick_i     = tk;
      flush_i        = fl;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic do_reset();
      idle();
      reset_i = 1'b1;
      #3;
      reset_i = 1'b0;
      #1;
   endtask

   task automatic check_result(input string tag, input logic hit, input logic [3:0] val,
                               input logic [4:0] idx);
      check({tag, "_rvalid"}, 64'(result_valid_o), 64'(1'b1));
      check({tag, "_hit"},    64'(result_hit_o),   64'(hit));
      check({tag, "_value"},  64'(result_value_o), 64'(val));
      check({tag, "_index"},  64'(result_index_o), 64'(idx));
   endtask

   vec_t vecs [8];

   initial begin
      int n;
      int low;
      int pulses;

      vecs[0] = '{1'b1, K0, 4'd3, 1'b1, K0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 6'd0};
      vecs[1] = '{1'b0, '0, 4'd0, 1'b1, K0, 1'b0, 1'b1, 1'b1, 4'd3, 5'd0, 6'd1};
      vecs[2] = '{1'b1, K1, 4'd7, 1'b1, K1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 6'd1};
      vecs[3] = '{1'b0, '0, 4'd0, 1'b1, K1, 1'b0, 1'b1, 1'b1, 4'd7, 5'd1, 6'd2};
      vecs[4] = '{1'b1, K0, 4'd5, 1'b0, K1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 6'd2};
      vecs[5] = '{1'b0, '0, 4'd0, 1'b1, K0, 1'b0, 1'b1, 1'b1, 4'd5, 5'd0, 6'd2};
      vecs[6] = '{1'b0, '0, 4'd0, 1'b1, K2, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 6'd2};
      vecs[7] = '{1'b0, '0, 4'd0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 6'd2};

      idle();
      reset_i = 1'b1;
      step();
      check("rst_learn_ready", 64'(learn_ready_o),   64'(1'b1));
      check("rst_rvalid",      64'(result_valid_o),  64'(1'b0));
      check("rst_hit",         64'(result_hit_o),    64'(1'b0));
      check("rst_dropped",     64'(learn_dropped_o), 64'(1'b0));
      check("rst_flush_done",  64'(flush_done_o),    64'(1'b0));
      check("rst_count",       64'(entry_count_o),   64'(0));
      reset_i = 1'b0;

      for (int v = 0; v < 8; v++) begin
         drive(vecs[v].lv, vecs[v].lk, vecs[v].lval, vecs[v].qv, vecs[v].qk, 1'b0, 1'b0);
         step();
         check($sformatf("vec%0d_dropped", v), 64'(learn_dropped_o), 64'(vecs[v].e_drop));
         check($sformatf("vec%0d_rvalid", v),  64'(result_valid_o),  64'(vecs[v].e_rv));
         check($sformatf("vec%0d_hit", v),     64'(result_hit_o),    64'(vecs[v].e_hit));
         check($sformatf("vec%0d_value", v),   64'(result_value_o),  64'(vecs[v].e_val));
         check($sformatf("vec%0d_index", v),   64'(result_index_o),  64'(vecs[v].e_idx));
         check($sformatf("vec%0d_count", v),   64'(entry_count_o),   64'(vecs[v].e_cnt));
      end

      // Fill the table, then overflow it.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         drive(1'b1, fkey(i), 4'(i), 1'b0, '0, 1'b0, 1'b0);
         step();
         if (i == 31) check("fill_no_drop_last", 64'(learn_dropped_o), 64'(1'b0));
      end
      drive(1'b1, fkey(32), 4'd1, 1'b0, '0, 1'b0, 1'b0);
      step();
      check("full_dropped", 64'(learn_dropped_o), 64'(1'b1));
      idle();
      step();
      check("full_drop_pulse", 64'(learn_dropped_o), 64'(1'b0));
      check("full_count",      64'(entry_count_o),   64'(32));
      drive(1'b0, '0, '0, 1'b1, fkey(32), 1'b0, 1'b0);
      step();
      check_result("full_lkp33", 1'b0, 4'd0, 5'd0);
      drive(1'b0, '0, '0, 1'b1, fkey(5), 1'b0, 1'b0);
      step();
      check_result("full_lkp5", 1'b1, 4'd5, 5'd5);
      drive(1'b1, fkey(5), 4'd9, 1'b0, '0, 1'b0, 1'b0);
      step();
      check("relearn_no_drop", 64'(learn_dropped_o), 64'(1'b0));
      drive(1'b0, '0, '0, 1'b1, fkey(5), 1'b0, 1'b0);
      step();
      check_result("relearn_lkp5", 1'b1, 4'd9, 5'd5);
      check("relearn_count", 64'(entry_count_o), 64'(32));

      // Aging to expiry; lookup in the expiring cycle still hits.
      do_reset();
      drive(1'b1, KA, 4'd4, 1'b0, '0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, KA, 1'b0, 1'b0);
      step();
      check_result("age14_lkp", 1'b1, 4'd4, 5'd0);
      drive(1'b0, '0, '0, 1'b1, KA, 1'b1, 1'b0);
      step();
      check_result("age15_same_cycle_lkp", 1'b1, 4'd4, 5'd0);
      drive(1'b0, '0, '0, 1'b1, KA, 1'b0, 1'b0);
      step();
      check_result("age15_after_lkp", 1'b0, 4'd0, 5'd0);
      idle();
      step();
      check("age15_count", 64'(entry_count_o), 64'(0));

      // Learn and tick together on an entry at age 1: learn refreshes it.
      drive(1'b1, KB, 4'd1, 1'b0, '0, 1'b0, 1'b0);
      step();
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
         step();
      end
      drive(1'b1, KB, 4'd2, 1'b0, '0, 1'b1, 1'b0);
      step();
      for (int i = 0; i < 14; i++) begin
         drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, KB, 1'b0, 1'b0);
      step();
      check_result("refresh_lkp", 1'b1, 4'd2, 5'd0);
      drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b1, KB, 1'b0, 1'b0);
      step();
      check_result("refresh_expired_lkp", 1'b0, 4'd0, 5'd0);

      // Flush of a partly filled table.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, fkey(i), 4'(i + 1), 1'b0, '0, 1'b0, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      step();
      idle();
      n = 0;
      low = 0;
      while (!flush_done_o && n < 100) begin
         if (!learn_ready_o) low++;
         if (n == 2) check_result("flush_uncleared_lkp", 1'b1, 4'd8, 5'd7);
         idle();
         if (n == 1) drive(1'b0, '0, '0, 1'b1, fkey(7), 1'b0, 1'b0);
         if (n == 3) flush_i = 1'b1;
         n++;
         step();
      end
      idle();
      check("flush_done_cycle",     64'(n),             64'(32));
      check("flush_ready_low",      64'(low),           64'(32));
      check("flush_ready_restored", 64'(learn_ready_o), 64'(1'b1));
      step();
      check("flush_done_pulse", 64'(flush_done_o),  64'(1'b0));
      check("flush_count",      64'(entry_count_o), 64'(0));
      drive(1'b0, '0, '0, 1'b1, fkey(3), 1'b0, 1'b0);
      step();
      check_result("flush_lkp3", 1'b0, 4'd0, 5'd0);

      // Reset in the middle of a flush aborts it without a done pulse.
      drive(1'b1, K0, 4'd6, 1'b0, '0, 1'b0, 1'b0);
      step();
      drive(1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b1);
      step();
      idle();
      repeat (5) step();
      do_reset();
      check("midflush_rst_ready", 64'(learn_ready_o), 64'(1'b1));
      check("midflush_rst_count", 64'(entry_count_o), 64'(0));
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (flush_done_o) pulses++;
      end
      check("midflush_no_done", 64'(pulses), 64'(0));
      drive(1'b0, '0, '0, 1'b1, K0, 1'b0, 1'b0);
      step();
      check_result("midflush_lkp", 1'b0, 4'd0, 5'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
